// File: rtl/wb_arb_id_if.sv
// wb_arb_id_if: bus bundle for the two-master arbiter; slave modport is the arbiter, master modport the masters and memory
interface wb_arb_id_if;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic        m0_we_i, m0_stb_i, m0_ack_o, m0_err_o;
  logic [31:0] m1_adr_i, m1_dat_o;
  logic        m1_stb_i, m1_ack_o, m1_err_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic        s_we_o, s_stb_o, s_ack_i;
  modport slave (
    input  m0_adr_i, m0_dat_i, m0_we_i, m0_stb_i, m1_adr_i, m1_stb_i, s_dat_i, s_ack_i,
    output m0_dat_o, m0_ack_o, m0_err_o, m1_dat_o, m1_ack_o, m1_err_o, s_adr_o, s_dat_o, s_we_o, s_stb_o
  );
  modport master (
    output m0_adr_i, m0_dat_i, m0_we_i, m0_stb_i, m1_adr_i, m1_stb_i, s_dat_i, s_ack_i,
    input  m0_dat_o, m0_ack_o, m0_err_o, m1_dat_o, m1_ack_o, m1_err_o, s_adr_o, s_dat_o, s_we_o, s_stb_o
  );
endinterface

// File: rtl/wb_arb_id.sv
// wb_arb_id: data/instruction master arbiter onto one memory slave, with watchdog error response.
// ARB_FIXED_PRIO_EN: m0 always wins ties and no last-grant register exists; otherwise round-robin.
module wb_arb_id #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input logic        clk,
  input logic        rst_n,
  wb_arb_id_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t      state_q, state_d;
  logic        gnt_q, gnt_d, we_q, we_d, err_q, err_d;
  logic [31:0] adr_q, adr_d, wdat_q, wdat_d, m0_dat_q, m0_dat_d, m1_dat_q, m1_dat_d;
  logic [7:0]  wd_q, wd_d;
  logic        req, win, rd;
  assign req = bus.m0_stb_i || bus.m1_stb_i;
`ifdef ARB_FIXED_PRIO_EN
  assign win = !bus.m0_stb_i;
`else
  logic last_q, last_d;
  assign win    = (bus.m0_stb_i && bus.m1_stb_i) ? !last_q : !bus.m0_stb_i;
  assign last_d = (state_q == IDLE && req) ? win : last_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= 1'b1;
    else last_q <= last_d;
`endif
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    err_d    = err_q;
    adr_d    = adr_q;
    wdat_d   = wdat_q;
    wd_d     = wd_q;
    m0_dat_d = m0_dat_q;
    m1_dat_d = m1_dat_q;
    case (state_q)
      IDLE: if (req) begin
        gnt_d   = win;
        adr_d   = win ? bus.m1_adr_i : bus.m0_adr_i;
        wdat_d  = win ? 32'h0 : bus.m0_dat_i;
        we_d    = !win && bus.m0_we_i;
        wd_d    = 8'd0;
        err_d   = 1'b0;
        state_d = BUS;
      end
      BUS: if (bus.s_ack_i) state_d = RESP;
      else begin
        wd_d = wd_q + 8'd1;
        if (wd_d == 8'(TIMEOUT_CYCLES)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d  = IDLE;
        m0_dat_d = (rd && !gnt_q) ? bus.s_dat_i : m0_dat_q;
        m1_dat_d = (rd && gnt_q) ? bus.s_dat_i : m1_dat_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      adr_q    <= 32'h0;
      wdat_q   <= 32'h0;
      wd_q     <= 8'd0;
      m0_dat_q <= 32'h0;
      m1_dat_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      err_q    <= err_d;
      adr_q    <= adr_d;
      wdat_q   <= wdat_d;
      wd_q     <= wd_d;
      m0_dat_q <= m0_dat_d;
      m1_dat_q <= m1_dat_d;
    end
  // read data is forwarded during RESP so it is visible alongside ack, then held by the register
  assign rd           = state_q == RESP && !we_q && !err_q;
  assign bus.s_stb_o  = state_q == BUS;
  assign bus.s_we_o   = state_q == BUS && we_q;
  assign bus.s_adr_o  = adr_q;
  assign bus.s_dat_o  = wdat_q;
  assign bus.m0_dat_o = (rd && !gnt_q) ? bus.s_dat_i : m0_dat_q;
  assign bus.m1_dat_o = (rd && gnt_q) ? bus.s_dat_i : m1_dat_q;
  assign bus.m0_ack_o = state_q == RESP && !gnt_q && !err_q;
  assign bus.m0_err_o = state_q == RESP && !gnt_q && err_q;
  assign bus.m1_ack_o = state_q == RESP && gnt_q && !err_q;
  assign bus.m1_err_o = state_q == RESP && gnt_q && err_q;
endmodule

// File: tb/tb_wb_arb_id.sv
// tb_wb_arb_id: scoreboard bench for wb_arb_id with a zero-wait memory model and TIMEOUT_CYCLES=4
module tb_wb_arb_id;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  wb_arb_id_if bus();
  wb_arb_id #(.TIMEOUT_CYCLES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  typedef struct packed {logic m; logic err; logic [31:0] dat;} exp_t;
  exp_t sb[$];
  exp_t e, got;
  int total = 0, bad = 0, stb_cyc = 0, we_cyc = 0;
  logic [31:0] wr_adr = 32'h0, wr_dat = 32'h0, mdl0 = 32'h0, mdl1 = 32'h0;
  logic ack_en = 1'b1;

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    return a == 32'h10 ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
  endfunction

  always @(posedge clk) begin
    #1;
    if (bus.s_stb_o) begin
      stb_cyc++;
      if (bus.s_we_o) begin
        we_cyc++;
        wr_adr = bus.s_adr_o;
        wr_dat = bus.s_dat_o;
      end
      bus.s_dat_i = rd_val(bus.s_adr_o);
    end
    bus.s_ack_i = bus.s_stb_o && ack_en;
  end

  always @(negedge clk) begin
    if (rst_n && (bus.m0_ack_o || bus.m0_err_o || bus.m1_ack_o || bus.m1_err_o)) begin
      total++;
      if ((bus.m0_ack_o || bus.m0_err_o) && (bus.m1_ack_o || bus.m1_err_o)) begin
        bad++;
        $display("FAIL two_grants m0_ack=%b m0_err=%b m1_ack=%b m1_err=%b required one master only",
                 bus.m0_ack_o, bus.m0_err_o, bus.m1_ack_o, bus.m1_err_o);
      end
      got.m   = bus.m1_ack_o || bus.m1_err_o;
      got.err = bus.m0_err_o || bus.m1_err_o;
      got.dat = got.m ? bus.m1_dat_o : bus.m0_dat_o;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_resp got m=%0d err=%0d dat=%h required none", got.m, got.err, got.dat);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL scoreboard got m=%0d err=%0d dat=%h required m=%0d err=%0d dat=%h",
                   got.m, got.err, got.dat, e.m, e.err, e.dat);
        end
      end
    end
  end

  task automatic expect_rsp(input logic m, input logic err, input logic rd, input logic [31:0] adr);
    if (rd && !err) begin
      if (m) mdl1 = rd_val(adr);
      else mdl0 = rd_val(adr);
    end
    sb.push_back(exp_t'({m, err, m ? mdl1 : mdl0}));
  endtask

  task automatic collect(input int want, input int lim, output int n, output int first, output logic gaps);
    int prev = 0;
    n = 0;
    first = 0;
    gaps = 1'b1;
    for (int i = 1; i <= lim && n < want; i++) begin
      @(posedge clk);
      #1;
      if (bus.m0_ack_o || bus.m0_err_o || bus.m1_ack_o || bus.m1_err_o) begin
        if (n == 0) first = i;
        else if (i - prev != 3) gaps = 1'b0;
        prev = i;
        n++;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.m0_ack_o, bus.m0_err_o, bus.m1_ack_o, bus.m1_err_o} !== 4'b0) begin
      bad++;
      $display("FAIL reset_ack_err got=%b required 0000", {bus.m0_ack_o, bus.m0_err_o, bus.m1_ack_o, bus.m1_err_o});
    end
    total++;
    if (bus.m0_dat_o !== 32'h0 || bus.m1_dat_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_dat got m0=%h m1=%h required 0", bus.m0_dat_o, bus.m1_dat_o);
    end
    total++;
    if (bus.s_stb_o !== 1'b0 || bus.s_we_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_slave_ctl got stb=%b we=%b required 0", bus.s_stb_o, bus.s_we_o);
    end
    total++;
    if (bus.s_adr_o !== 32'h0 || bus.s_dat_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_latched got adr=%h dat=%h required 0", bus.s_adr_o, bus.s_dat_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_m1_read;
    int n, f;
    logic g;
    bus.m1_adr_i = 32'h10;
    bus.m1_stb_i = 1'b1;
    expect_rsp(1'b1, 1'b0, 1'b1, 32'h10);
    collect(1, 20, n, f, g);
    total++;
    if (f !== 2) begin
      bad++;
      $display("FAIL m1_read_latency got edge=%0d required 2", f);
    end
    total++;
    if (bus.m1_dat_o !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL m1_read_data got=%h required deadbeef", bus.m1_dat_o);
    end
    total++;
    if (bus.m0_ack_o !== 1'b0 || bus.m0_err_o !== 1'b0 || bus.m0_dat_o !== mdl0) begin
      bad++;
      $display("FAIL m0_quiet got ack=%b err=%b dat=%h required 0 0 %h", bus.m0_ack_o, bus.m0_err_o, bus.m0_dat_o, mdl0);
    end
    bus.m1_stb_i = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.m1_dat_o !== 32'hDEAD_BEEF || bus.m1_ack_o !== 1'b0) begin
      bad++;
      $display("FAIL m1_dat_hold got dat=%h ack=%b required deadbeef 0", bus.m1_dat_o, bus.m1_ack_o);
    end
  endtask

  task automatic test_m0_write;
    int n, f, w0;
    logic g;
    w0 = we_cyc;
    bus.m0_adr_i = 32'h20;
    bus.m0_dat_i = 32'h1234_5678;
    bus.m0_we_i  = 1'b1;
    bus.m0_stb_i = 1'b1;
    expect_rsp(1'b0, 1'b0, 1'b0, 32'h20);
    collect(1, 20, n, f, g);
    total++;
    if (f !== 2) begin
      bad++;
      $display("FAIL m0_write_latency got edge=%0d required 2", f);
    end
    total++;
    if (we_cyc - w0 !== 1) begin
      bad++;
      $display("FAIL m0_write_we_cycles got=%0d required 1", we_cyc - w0);
    end
    total++;
    if (wr_adr !== 32'h20 || wr_dat !== 32'h1234_5678) begin
      bad++;
      $display("FAIL m0_write_bus got adr=%h dat=%h required 00000020 12345678", wr_adr, wr_dat);
    end
    bus.m0_stb_i = 1'b0;
    bus.m0_we_i  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stb_drop;
    int n, f;
    logic g;
    bus.m1_adr_i = 32'h30;
    bus.m1_stb_i = 1'b1;
    expect_rsp(1'b1, 1'b0, 1'b1, 32'h30);
    @(posedge clk);
    #1;
    bus.m1_stb_i = 1'b0;
    collect(1, 20, n, f, g);
    total++;
    if (f !== 1 || bus.m1_dat_o !== rd_val(32'h30)) begin
      bad++;
      $display("FAIL stb_drop got edge=%0d dat=%h required 1 %h", f, bus.m1_dat_o, rd_val(32'h30));
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout;
    int n, f, s0;
    logic g;
    ack_en = 1'b0;
    s0 = stb_cyc;
    bus.m0_adr_i = 32'h44;
    bus.m0_stb_i = 1'b1;
    expect_rsp(1'b0, 1'b1, 1'b1, 32'h44);
    collect(1, 50, n, f, g);
    total++;
    if (f !== 5) begin
      bad++;
      $display("FAIL timeout_latency got edge=%0d required 5", f);
    end
    total++;
    if (bus.m0_err_o !== 1'b1 || bus.m0_ack_o !== 1'b0) begin
      bad++;
      $display("FAIL timeout_flags got err=%b ack=%b required 1 0", bus.m0_err_o, bus.m0_ack_o);
    end
    total++;
    if (stb_cyc - s0 !== 4) begin
      bad++;
      $display("FAIL timeout_bus_cycles got=%0d required 4", stb_cyc - s0);
    end
    bus.m0_stb_i = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (bus.s_stb_o !== 1'b0 || bus.m0_err_o !== 1'b0) begin
      bad++;
      $display("FAIL timeout_idle got stb=%b err=%b required 0 0", bus.s_stb_o, bus.m0_err_o);
    end
    ack_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int n, f;
    logic g;
    bus.m1_adr_i = 32'h50;
    bus.m1_stb_i = 1'b1;
    expect_rsp(1'b1, 1'b0, 1'b1, 32'h50);
    expect_rsp(1'b1, 1'b0, 1'b1, 32'h50);
    collect(2, 30, n, f, g);
    bus.m1_stb_i = 1'b0;
    total++;
    if (n !== 2 || f !== 2 || g !== 1'b1) begin
      bad++;
      $display("FAIL back_to_back got n=%0d first=%0d gaps_ok=%b required 2 2 1", n, f, g);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n, f;
    logic g;
    ack_en = 1'b0;
    bus.m0_adr_i = 32'h60;
    bus.m0_stb_i = 1'b1;
    @(posedge clk);
    #2;
    total++;
    if (bus.s_stb_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_bus got stb=%b required 1", bus.s_stb_o);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.s_stb_o !== 1'b0 || bus.m1_dat_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid_async got stb=%b m1_dat=%h required 0 0", bus.s_stb_o, bus.m1_dat_o);
    end
    bus.m0_stb_i = 1'b0;
    mdl0 = 32'h0;
    mdl1 = 32'h0;
    @(negedge clk);
    rst_n  = 1'b1;
    ack_en = 1'b1;
    collect(1, 8, n, f, g);
    total++;
    if (n !== 0) begin
      bad++;
      $display("FAIL reset_mid_no_resp got n=%0d required 0", n);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin;
    int n, f;
    logic g;
    rst_n = 1'b0;
    @(negedge clk);
    mdl0 = 32'h0;
    mdl1 = 32'h0;
    bus.m0_adr_i = 32'h100;
    bus.m0_we_i  = 1'b0;
    bus.m1_adr_i = 32'h200;
    bus.m0_stb_i = 1'b1;
    bus.m1_stb_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (!FIXED && i % 2 == 1) expect_rsp(1'b1, 1'b0, 1'b1, 32'h200);
      else expect_rsp(1'b0, 1'b0, 1'b1, 32'h100);
    end
    rst_n = 1'b1;
    collect(4, 40, n, f, g);
    bus.m0_stb_i = 1'b0;
    bus.m1_stb_i = 1'b0;
    total++;
    if (n !== 4 || f !== 2 || g !== 1'b1) begin
      bad++;
      $display("FAIL round_robin got n=%0d first=%0d gaps_ok=%b required 4 2 1", n, f, g);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bus.m0_adr_i = 32'h0;
    bus.m0_dat_i = 32'h0;
    bus.m0_we_i  = 1'b0;
    bus.m0_stb_i = 1'b0;
    bus.m1_adr_i = 32'h0;
    bus.m1_stb_i = 1'b0;
    bus.s_dat_i  = 32'h0;
    bus.s_ack_i  = 1'b0;
    test_reset;
    test_m1_read;
    test_m0_write;
    test_stb_drop;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    test_round_robin;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
